// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures register-file writes into a FIFO and drains each as a 3-beat stream.
// Optional build macro WB_TRACE_SKIP_ZERO_EN drops writes to $0 before they reach the FIFO.
module wb_trace_buffer #(
    parameter int          DEPTH = 16,
    parameter int          AW    = 4,
    parameter logic [7:0]  TAG   = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_we,
    input  logic [31:0]   wb_pc,
    input  logic [4:0]    wb_addr,
    input  logic [31:0]   wb_data,
    output logic          tr_valid,
    input  logic          tr_ready,
    output logic [31:0]   tr_data,
    output logic          tr_last,
    output logic [15:0]   ovf_cnt,
    output logic [AW:0]   level
);

    // state | meaning
    // IDLE  | no record held, waiting for FIFO data
    // B1    | presenting PC beat
    // B2    | presenting tag + register number beat
    // B3    | presenting data beat (last)
    typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [68:0]   mem [DEPTH];
    logic [68:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   hold_pc, hold_data;
    logic [4:0]    hold_addr;
    logic          empty, full, cap, hs, push, pop;

`ifdef WB_TRACE_SKIP_ZERO_EN
    assign cap = wb_we & (wb_addr != 5'd0);
`else
    assign cap = wb_we;
`endif

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign hs    = tr_valid & tr_ready;
    assign pop   = !empty & ((state == IDLE) | ((state == B3) & hs));
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push  = cap & (!full | pop);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wb_pc, wb_addr, wb_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ovf_cnt   <= '0;
            hold_pc   <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                hold_pc   <= head[68:37];
                hold_addr <= head[36:32];
                hold_data <= head[31:0];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (cap && !push && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!empty) state_nxt = B1;
            B1:   if (hs) state_nxt = B2;
            B2:   if (hs) state_nxt = B3;
            B3:   if (hs) state_nxt = empty ? IDLE : B1;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tr_valid = 1'b0;
        tr_data  = '0;
        tr_last  = 1'b0;
        case (state)
            B1: begin
                tr_valid = 1'b1;
                tr_data  = hold_pc;
            end
            B2: begin
                tr_valid = 1'b1;
                tr_data  = {TAG, 19'b0, hold_addr};
            end
            B3: begin
                tr_valid = 1'b1;
                tr_data  = hold_data;
                tr_last  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (default DEPTH=16).
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [31:0] wb_pc;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        tr_valid;
    logic        tr_ready;
    logic [31:0] tr_data;
    logic        tr_last;
    logic [15:0] ovf_cnt;
    logic [4:0]  level;

    int total  = 0;
    int passed = 0;

    wb_trace_buffer dut (
        .clk(clk), .reset(reset), .wb_we(wb_we), .wb_pc(wb_pc), .wb_addr(wb_addr),
        .wb_data(wb_data), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
        .tr_last(tr_last), .ovf_cnt(ovf_cnt), .level(level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_pc = pc; wb_addr = a; wb_data = d;
    endtask

    // Waits (bounded) for a record to start, then checks its three beats with tr_ready high.
    task automatic rec(input string tag, input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        for (int k = 0; k < 8 && !tr_valid; k++) tick();
        chk({tag, "_valid"}, 32'(tr_valid), 32'd1);
        chk({tag, "_b1"}, tr_data, pc);
        chk({tag, "_b1_last"}, 32'(tr_last), 32'd0);
        tick();
        chk({tag, "_b2"}, tr_data, {8'hA5, 19'b0, a});
        tick();
        chk({tag, "_b3"}, tr_data, d);
        chk({tag, "_b3_last"}, 32'(tr_last), 32'd1);
        tick();
    endtask

    initial begin
        reset = 1'b0; wb_we = 1'b0; wb_pc = '0; wb_addr = '0; wb_data = '0; tr_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(tr_valid), 32'd0);
        chk("rst_data", tr_data, 32'd0);
        chk("rst_last", 32'(tr_last), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // single record, sink always ready
        tr_ready = 1'b1;
        wr(32'h0000_3000, 5'd8, 32'h1234_5678);
        tick();
        wb_we = 1'b0;
        chk("t1_level_push", 32'(level), 32'd1);
        chk("t1_idle_valid", 32'(tr_valid), 32'd0);
        tick();
        chk("t1_b1", tr_data, 32'h0000_3000);
        chk("t1_b1_valid", 32'(tr_valid), 32'd1);
        chk("t1_b1_last", 32'(tr_last), 32'd0);
        chk("t1_level_pop", 32'(level), 32'd0);
        tick();
        chk("t1_b2", tr_data, 32'hA500_0008);
        chk("t1_b2_last", 32'(tr_last), 32'd0);
        tick();
        chk("t1_b3", tr_data, 32'h1234_5678);
        chk("t1_b3_last", 32'(tr_last), 32'd1);
        tick();
        chk("t1_done_valid", 32'(tr_valid), 32'd0);
        chk("t1_done_level", 32'(level), 32'd0);

        // back-pressure held in B2
        wr(32'h0000_3000, 5'd8, 32'h1234_5678);
        tick();
        wb_we = 1'b0;
        tick();
        chk("t2_b1", tr_data, 32'h0000_3000);
        tick();
        tr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_data", tr_data, 32'hA500_0008);
            chk("t2_hold_valid", 32'(tr_valid), 32'd1);
            tick();
        end
        chk("t2_hold_last", 32'(tr_last), 32'd0);
        tr_ready = 1'b1;
        tick();
        chk("t2_b3", tr_data, 32'h1234_5678);
        chk("t2_b3_last", 32'(tr_last), 32'd1);
        tick();
        chk("t2_done_valid", 32'(tr_valid), 32'd0);

        // 20 writes into a stalled sink: 1 held + 16 queued, 3 dropped
        tr_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr(32'h0000_1000 + 32'(4 * i), 5'(i + 1), 32'hD000_0000 + 32'(i));
            tick();
        end
        wb_we = 1'b0;
        chk("t3_level_full", 32'(level), 32'd16);
        chk("t3_ovf", 32'(ovf_cnt), 32'd3);
        chk("t3_head_b1", tr_data, 32'h0000_1000);
        tick();
        chk("t3_stall_ovf", 32'(ovf_cnt), 32'd3);

        // full FIFO, push on the same edge as the B3 handshake/pop
        tr_ready = 1'b1;
        tick();
        chk("t4_r0_b2", tr_data, 32'hA500_0001);
        tick();
        chk("t4_r0_b3", tr_data, 32'hD000_0000);
        chk("t4_r0_last", 32'(tr_last), 32'd1);
        wr(32'h0000_2000, 5'd30, 32'hBEEF_0001);
        tick();
        wb_we = 1'b0;
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_ovf", 32'(ovf_cnt), 32'd3);
        for (int i = 1; i <= 16; i++)
            rec("t3_drain", 32'h0000_1000 + 32'(4 * i), 5'(i + 1), 32'hD000_0000 + 32'(i));
        rec("t4_new", 32'h0000_2000, 5'd30, 32'hBEEF_0001);
        chk("t4_end_valid", 32'(tr_valid), 32'd0);
        chk("t4_end_level", 32'(level), 32'd0);

        // reset asserted while in B2
        wr(32'h0000_5000, 5'd3, 32'h0000_0033);
        tick();
        wb_we = 1'b0;
        tick();
        tick();
        chk("t5_in_b2", tr_data, 32'hA500_0003);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_valid", 32'(tr_valid), 32'd0);
        chk("t5_ovf", 32'(ovf_cnt), 32'd0);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_data", tr_data, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // write to $0 followed by write to $2
        wr(32'h0000_4000, 5'd0, 32'h1111_1111);
        tick();
        wr(32'h0000_4004, 5'd2, 32'h2222_2222);
        tick();
        wb_we = 1'b0;
`ifdef WB_TRACE_SKIP_ZERO_EN
        rec("t6_r2", 32'h0000_4004, 5'd2, 32'h2222_2222);
`else
        rec("t6_r0", 32'h0000_4000, 5'd0, 32'h1111_1111);
        rec("t6_r2", 32'h0000_4004, 5'd2, 32'h2222_2222);
`endif
        tick();
        chk("t6_end_valid", 32'(tr_valid), 32'd0);
        chk("t6_end_level", 32'(level), 32'd0);
        chk("t6_ovf", 32'(ovf_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
